// File: rtl/row_render_pipe_if.sv
// Pixel-pipe bundle between the ray tracer (line attributes, pixel stream) and the VGA pixel mux.
// master drives line/pixel inputs and consumes the coloured result; slave is the renderer.
interface row_render_pipe_if #(
  parameter int HPOS_BITS = 10,
  parameter int SIZE_BITS = 11,
  parameter int TEX_BITS  = 6
);
  logic                 line_load;
  logic [1:0]           wall;
  logic                 side;
  logic [SIZE_BITS-1:0] size;
  logic [TEX_BITS-1:0]  texu;
  logic                 vinf;
  logic [TEX_BITS-1:0]  leak;

  logic                 pix_valid;
  logic [HPOS_BITS-1:0] hpos;
  logic [TEX_BITS-1:0]  texv;
  logic                 ext_en;
  logic [5:0]           ext_rgb;
  logic [5:0]           bg_rgb;

  logic                 out_valid;
  logic                 hit;
  logic [5:0]           rgb;

  modport master (
    output line_load, wall, side, size, texu, vinf, leak,
    output pix_valid, hpos, texv, ext_en, ext_rgb, bg_rgb,
    input  out_valid, hit, rgb
  );

  modport slave (
    input  line_load, wall, side, size, texu, vinf, leak,
    input  pix_valid, hpos, texv, ext_en, ext_rgb, bg_rgb,
    output out_valid, hit, rgb
  );
endinterface

// File: rtl/row_render_pipe.sv
// Per-row wall renderer: latches line attributes and visible span, then colours each pixel in 2 stages.
// Latency 2 clocks pixel->out_valid, 1 pixel/clock; no backpressure, pipeline never stalls.
module row_render_pipe #(
  parameter int H_VIEW    = 640,
  parameter int HPOS_BITS = 10,
  parameter int SIZE_BITS = 11,
  parameter int TEX_BITS  = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  row_render_pipe_if.slave bus
);

  localparam int HALF = H_VIEW / 2;
  localparam int SW   = HPOS_BITS + 1;
  localparam int EW   = ((SIZE_BITS > SW) ? SIZE_BITS : SW) + 1;

  typedef struct packed {
    logic [1:0]          wall;
    logic                side;
    logic [TEX_BITS-1:0] texu;
    logic                vinf;
    logic [TEX_BITS-1:0] leak;
    logic                full;
    logic [SW-1:0]       span_lo;
    logic [SW-1:0]       span_hi;
  } line_t;

  line_t line_q;
  line_t line_n;

  // ---------------- line attribute capture ----------------
  logic [EW-1:0] size_e;
  logic [EW-1:0] half_e;
  logic [EW-1:0] hi_e;
  logic [EW-1:0] last_e;

  assign size_e = EW'(bus.size);
  assign half_e = EW'(HALF);
  assign last_e = EW'(H_VIEW - 1);
  assign hi_e   = half_e + size_e;

  always_comb begin
    line_n         = line_q;
    line_n.wall    = bus.wall;
    line_n.side    = bus.side;
    line_n.texu    = bus.texu;
    line_n.vinf    = bus.vinf;
    line_n.leak    = bus.leak;
    line_n.full    = (size_e > half_e);
    // A full-height wall ignores the span, so park it at the whole trace.
    if (line_n.full) begin
      line_n.span_lo = '0;
      line_n.span_hi = SW'(H_VIEW - 1);
    end else begin
      line_n.span_lo = SW'(half_e - size_e);
      line_n.span_hi = (hi_e > last_e) ? SW'(last_e) : SW'(hi_e);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q         <= '0;
      line_q.span_lo <= SW'(HALF);
      line_q.span_hi <= SW'(HALF);
    end else if (bus.line_load) begin
      line_q <= line_n;
    end
  end

  // ---------------- stage 1: hit classification ----------------
  logic          acc;
  logic [SW-1:0] hpos_e;
  logic          in_span;
  logic          left_half;
  logic          hit_n;

  assign acc       = bus.pix_valid & ~bus.line_load;
  assign hpos_e    = {1'b0, bus.hpos};
  assign in_span   = (line_q.span_lo <= hpos_e) && (hpos_e <= line_q.span_hi);
  assign left_half = (hpos_e < SW'(HALF));
  // texv==0 on the right half is the floor row, never wall unless infinite height.
  assign hit_n     = (bus.texv >= line_q.leak) &&
                     (line_q.vinf || ((left_half || (bus.texv != '0)) && (line_q.full || in_span)));

  logic                v1;
  logic                hit1;
  logic [TEX_BITS-1:0] u1;
  logic [TEX_BITS-1:0] t1;
  logic                ee1;
  logic [5:0]          bg1;
  logic [1:0]          wall1;
  logic                side1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1    <= 1'b0;
      hit1  <= 1'b0;
      u1    <= '0;
      t1    <= '0;
      ee1   <= 1'b0;
      bg1   <= '0;
      wall1 <= '0;
      side1 <= 1'b0;
    end else begin
      v1 <= acc;
      if (acc) begin
        hit1  <= hit_n;
        u1    <= line_q.texu;
        t1    <= bus.texv;
        ee1   <= bus.ext_en;
        bg1   <= bus.bg_rgb;
        wall1 <= line_q.wall;
        side1 <= line_q.side;
      end
    end
  end

  // ---------------- stage 2: colour ----------------
  function automatic logic [5:0] shade(input logic s, input logic [5:0] lt, input logic [5:0] dk);
    return s ? lt : dk;
  endfunction

  logic       mortar;
  logic [5:0] gen;

  always_comb begin
    gen    = '0;
    mortar = ((u1[4:0] == 5'd6) && !t1[3]) || ((u1[4:0] == 5'd24) && t1[3]);
    case (wall1)
      2'd0: gen = shade(side1, 6'b000011, 6'b000010);
      2'd1: gen = {u1[0], side1, u1[2], side1, u1[4], side1} ^
                  {t1[0], 1'b0,  t1[2], 1'b0,  t1[4], 1'b0};
      2'd2: begin
        if (mortar)
          gen = shade(side1, 6'b101010, 6'b010101);
        else if (t1[2:0] == 3'd0)
          gen = u1[0] ? shade(side1, 6'b010101, 6'b000000)
                      : shade(side1, 6'b101010, 6'b010101);
        else if (t1[2:0] == 3'd7)
          gen = shade(side1, 6'b110100, 6'b110000);
        else if (t1[2:0] == 3'd1)
          gen = shade(side1, 6'b010000, 6'b000000);
        else
          gen = shade(side1, 6'b110000, 6'b100000);
      end
      default: begin
        if ((u1[3:1] == 3'd0) || (t1[3:1] == 3'd7))
          gen = shade(side1, 6'b110111, 6'b100010);
        else if ((u1[3:1] == 3'd7) || (t1[3:1] == 3'd0))
          gen = shade(side1, 6'b100010, 6'b010001);
        else
          gen = shade(side1, 6'b100011, 6'b010010);
      end
    endcase
  end

  // Dark side halves each 2-bit channel; ext_rgb arrives one cycle after its pixel.
  logic [5:0] ext_dim;
  logic [5:0] pix_rgb;

  assign ext_dim = side1 ? bus.ext_rgb
                         : {1'b0, bus.ext_rgb[5], 1'b0, bus.ext_rgb[3], 1'b0, bus.ext_rgb[1]};
  assign pix_rgb = !hit1 ? bg1 : (ee1 ? ext_dim : gen);

  logic       ov_q;
  logic       hit_q;
  logic [5:0] rgb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ov_q  <= 1'b0;
      hit_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      ov_q  <= v1;
      hit_q <= v1 & hit1;
      if (v1) rgb_q <= pix_rgb;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.hit       = hit_q;
  assign bus.rgb       = rgb_q;

  logic unused_tex;
  assign unused_tex = ^{u1, t1};

endmodule

// File: tb/tb_row_render_pipe.sv
// Directed bench for row_render_pipe: scoreboard model of hit/colour plus literal spot checks.
module tb_row_render_pipe;

  localparam int H_VIEW    = 640;
  localparam int HPOS_BITS = 10;
  localparam int SIZE_BITS = 11;
  localparam int TEX_BITS  = 6;
  localparam int HALF      = H_VIEW / 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  row_render_pipe_if #(.HPOS_BITS(HPOS_BITS), .SIZE_BITS(SIZE_BITS), .TEX_BITS(TEX_BITS)) bus();

  row_render_pipe #(.H_VIEW(H_VIEW), .HPOS_BITS(HPOS_BITS), .SIZE_BITS(SIZE_BITS), .TEX_BITS(TEX_BITS))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct { int due; bit h; logic [5:0] rgb; } exp_t;
  typedef struct { bit h; logic [5:0] rgb; } obs_t;

  exp_t q[$];
  obs_t outlog[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   running = 0;
  int   first_pv = -1;
  int   first_ov = -1;
  logic [5:0] last_rgb = '0;
  logic [5:0] pend_ext = '0;

  // model line state and staged values for the next load
  logic [1:0] m_wall; bit m_side; int m_size; logic [5:0] m_texu; bit m_vinf; int m_leak;
  logic [1:0] l_wall; bit l_side; int l_size; logic [5:0] l_texu; bit l_vinf; int l_leak;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_hit(input int hp, input int tv);
    int lo, hi;
    lo = HALF - m_size;
    hi = HALF + m_size;
    if (hi > H_VIEW - 1) hi = H_VIEW - 1;
    if (tv < m_leak) return 0;
    if (m_vinf) return 1;
    if (hp >= HALF && tv == 0) return 0;
    return (m_size > HALF) || (hp >= lo && hp <= hi);
  endfunction

  function automatic logic [5:0] m_dim(input logic [5:0] x);
    logic [5:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) r = r | 6'((((int'(x) >> (2 * c)) & 3) / 2) << (2 * c));
    return r;
  endfunction

  function automatic logic [5:0] m_tex(input logic [1:0] w, input bit s, input logic [5:0] u, input logic [5:0] v);
    logic [5:0] lt, dk;
    int ub, vb, u31, v31;
    ub = int'(u) % 32; vb = int'(v) % 8; u31 = (int'(u) / 2) % 8; v31 = (int'(v) / 2) % 8;
    if (w == 2'd1) return {u[0], s, u[2], s, u[4], s} ^ {v[0], 1'b0, v[2], 1'b0, v[4], 1'b0};
    if (w == 2'd0) begin lt = 6'b000011; dk = 6'b000010; end
    else if (w == 2'd2) begin
      if ((ub == 6 && !v[3]) || (ub == 24 && v[3])) begin lt = 6'b101010; dk = 6'b010101; end
      else if (vb == 0 && u[0])  begin lt = 6'b010101; dk = 6'b000000; end
      else if (vb == 0)          begin lt = 6'b101010; dk = 6'b010101; end
      else if (vb == 7)          begin lt = 6'b110100; dk = 6'b110000; end
      else if (vb == 1)          begin lt = 6'b010000; dk = 6'b000000; end
      else                       begin lt = 6'b110000; dk = 6'b100000; end
    end else begin
      if (u31 == 0 || v31 == 7)      begin lt = 6'b110111; dk = 6'b100010; end
      else if (u31 == 7 || v31 == 0) begin lt = 6'b100010; dk = 6'b010001; end
      else                           begin lt = 6'b100011; dk = 6'b010010; end
    end
    return s ? lt : dk;
  endfunction

  task automatic model_reset();
    m_wall = '0; m_side = 0; m_size = 0; m_texu = '0; m_vinf = 0; m_leak = 0;
  endtask

  task automatic set_line(input int w, input bit s, input int sz, input int tu, input bit vi, input int lk);
    l_wall = 2'(w); l_side = s; l_size = sz; l_texu = 6'(tu); l_vinf = vi; l_leak = lk;
    bus.wall = l_wall; bus.side = s; bus.size = SIZE_BITS'(sz);
    bus.texu = TEX_BITS'(tu); bus.vinf = vi; bus.leak = TEX_BITS'(lk);
  endtask

  task automatic step(input bit ld, input bit pv, input int hp, input int tv,
                      input bit ee, input logic [5:0] er, input logic [5:0] bg);
    exp_t e;
    bus.line_load = ld; bus.pix_valid = pv; bus.hpos = HPOS_BITS'(hp); bus.texv = TEX_BITS'(tv);
    bus.ext_en = ee; bus.bg_rgb = bg; bus.ext_rgb = pend_ext;
    if (pv && !ld) begin
      e.due = cyc + 2;
      e.h   = m_hit(hp, tv);
      e.rgb = !e.h ? bg : (ee ? (m_side ? er : m_dim(er)) : m_tex(m_wall, m_side, m_texu, 6'(tv)));
      q.push_back(e);
      if (first_pv < 0) first_pv = cyc;
    end
    pend_ext = er;
    if (ld) begin
      m_wall = l_wall; m_side = l_side; m_size = l_size; m_texu = l_texu; m_vinf = l_vinf; m_leak = l_leak;
    end
    @(posedge clk); #1;
  endtask

  task automatic pix(input int hp, input int tv, input bit ee, input logic [5:0] er, input logic [5:0] bg);
    step(0, 1, hp, tv, ee, er, bg);
  endtask

  task automatic load();
    step(1, 0, 0, 0, 0, 6'd0, 6'd0);
  endtask

  task automatic drain();
    repeat (4) step(0, 0, 0, 0, 0, 6'd0, 6'd0);
  endtask

  always @(negedge clk) begin
    if (running && reset_n) begin
      bit ev;
      exp_t e;
      obs_t o;
      while (q.size() > 0 && q[0].due < cyc) begin
        e = q.pop_front();
        chk("late_output", 0, 1);
      end
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("out_valid", int'(bus.out_valid), int'(ev));
      if (ev) begin
        e = q.pop_front();
        chk("hit", int'(bus.hit), int'(e.h));
        chk("rgb", int'(bus.rgb), int'(e.rgb));
        last_rgb = e.rgb;
        o.h = bus.hit; o.rgb = bus.rgb;
        outlog.push_back(o);
      end else begin
        chk("idle_hit", int'(bus.hit), 0);
        chk("rgb_hold", int'(bus.rgb), int'(last_rgb));
      end
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    bus.line_load = 0; bus.pix_valid = 0; bus.hpos = '0; bus.texv = '0;
    bus.ext_en = 0; bus.ext_rgb = '0; bus.bg_rgb = '0;
    set_line(0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_hit", int'(bus.hit), 0);
    chk("reset_rgb", int'(bus.rgb), 0);
    #6 reset_n = 1;
    running = 1;
    @(posedge clk); #1;

    // 1: span of a size-100 wall
    set_line(0, 1, 100, 0, 0, 0); load();
    for (int h = 0; h < H_VIEW; h++) pix(h, 5, 0, 6'd0, 6'b001100);
    drain();
    chk("t1_count", outlog.size(), 640);
    hits = 0;
    foreach (outlog[i]) hits += int'(outlog[i].h);
    chk("t1_hits", hits, 201);
    chk("t1_219", int'(outlog[219].h), 0);
    chk("t1_220", int'(outlog[220].h), 1);
    chk("t1_420", int'(outlog[420].h), 1);
    chk("t1_421", int'(outlog[421].h), 0);
    chk("t1_latency", first_ov - first_pv, 2);
    outlog.delete();

    // 2: full wall and floor row
    set_line(1, 1, 400, 5, 0, 0); load();
    pix(639, 0, 0, 6'd0, 6'd0); pix(100, 0, 0, 6'd0, 6'd0); pix(639, 1, 0, 6'd0, 6'd0);
    drain();
    chk("t2_639_0", int'(outlog[0].h), 0);
    chk("t2_100_0", int'(outlog[1].h), 1);
    chk("t2_639_1", int'(outlog[2].h), 1);
    outlog.delete();

    // 3: leak threshold with infinite height
    set_line(0, 1, 0, 0, 1, 10); load();
    pix(0, 9, 0, 6'd0, 6'b001100); pix(0, 10, 0, 6'd0, 6'b001100);
    drain();
    chk("t3_leak_hit", int'(outlog[0].h), 0);
    chk("t3_leak_bg", int'(outlog[0].rgb), int'(6'b001100));
    chk("t3_at_leak", int'(outlog[1].h), 1);
    chk("t3_rgb", int'(outlog[1].rgb), int'(6'b000011));
    outlog.delete();

    // 4: brick mortar, then dimmed external texel
    set_line(2, 1, 400, 6, 0, 0); load();
    pix(100, 3, 0, 6'd0, 6'b000111);
    set_line(2, 0, 400, 6, 0, 0); load();
    pix(100, 3, 1, 6'b111001, 6'd0);
    drain();
    chk("t4_mortar", int'(outlog[0].rgb), int'(6'b101010));
    chk("t4_ext_dim", int'(outlog[1].rgb), int'(6'b010100));
    outlog.delete();

    // texture sweep across walls, sides, u and v
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 2; s++) begin
        set_line(w, s[0], 400, (w * 11 + s * 13 + 6) % 64, 0, 0); load();
        for (int tv = 0; tv < 16; tv++) pix(100, tv * 3 + s, (tv % 5) == 4, 6'(tv * 7 + w), 6'd0);
        set_line(w, s[0], 400, 24, 0, 0); load();
        for (int tv = 0; tv < 16; tv++) pix(50, tv, 0, 6'd0, 6'd0);
      end
    drain();
    outlog.delete();

    // span boundaries: size=HALF, size=1, max size
    set_line(0, 1, HALF, 0, 0, 0); load();
    pix(0, 1, 0, 6'd0, 6'd5); pix(639, 1, 0, 6'd0, 6'd5);
    set_line(0, 1, 1, 0, 0, 0); load();
    for (int h = 317; h < 324; h++) pix(h, 2, 0, 6'd0, 6'd5);
    set_line(0, 0, 2047, 0, 0, 0); load();
    pix(0, 1, 0, 6'd0, 6'd5); pix(639, 1, 0, 6'd0, 6'd5);
    drain();
    chk("half_lo", int'(outlog[0].h), 1);
    chk("half_hi", int'(outlog[1].h), 1);
    chk("size1_318", int'(outlog[3].h), 0);
    chk("size1_319", int'(outlog[4].h), 1);
    chk("maxsize", int'(outlog[10].h), 1);
    outlog.delete();

    // 5: pixel coincident with line_load is dropped; next pixel sees the new span
    set_line(0, 1, 0, 0, 0, 0);
    step(1, 1, 100, 5, 0, 6'd0, 6'd0);
    pix(100, 5, 0, 6'd0, 6'd0); pix(320, 5, 0, 6'd0, 6'd0);
    drain();
    chk("t5_count", outlog.size(), 2);
    chk("t5_new_span_out", int'(outlog[0].h), 0);
    chk("t5_new_span_in", int'(outlog[1].h), 1);
    outlog.delete();

    // 6: async reset mid-stream
    set_line(2, 1, 400, 0, 0, 0); load();
    for (int h = 0; h < 6; h++) pix(h, 2, 0, 6'd0, 6'b110011);
    #2 reset_n = 0;
    #1;
    chk("t6_rst_valid", int'(bus.out_valid), 0);
    chk("t6_rst_hit", int'(bus.hit), 0);
    chk("t6_rst_rgb", int'(bus.rgb), 0);
    bus.pix_valid = 0; bus.line_load = 0;
    q.delete(); outlog.delete(); pend_ext = '0; last_rgb = '0;
    model_reset();
    @(posedge clk); #3 reset_n = 1;
    @(posedge clk); #1;
    repeat (3) step(0, 0, 0, 0, 0, 6'd0, 6'd0);
    for (int h = 316; h < 325; h++) pix(h, 5, 0, 6'd0, 6'b110011);
    drain();
    chk("t6_count", outlog.size(), 9);
    chk("t6_319", int'(outlog[3].h), 0);
    chk("t6_320", int'(outlog[4].h), 1);
    chk("t6_320_rgb", int'(outlog[4].rgb), int'(6'b000010));
    chk("t6_321", int'(outlog[5].h), 0);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_render_pipe.md
Name: row_render_pipe

Overview:
- Pipelined, parametrised successor to the combinational per-row wall renderer.
- Per-line wall attributes are latched once per line, and the visible span is precomputed.
- Each pixel (hpos, texv) then flows through a 2-stage pipeline. The output is a registered hit flag plus final pixel colour: generated texture, external texel (side-dimmed), or background.
- Sits between the ray tracer's line attributes / texture-address logic and the VGA pixel mux.

Parameters:
H_VIEW, 640, visible trace length in pixels; HALF = H_VIEW/2.
HPOS_BITS, 10, width of hpos; must satisfy 2^HPOS_BITS >= H_VIEW.
SIZE_BITS, 11, width of wall half-height size.
TEX_BITS, 6, texture coordinate width (texture is 2^TEX_BITS square); must be >= 5.

Ports:
clk  in  1  system clock, all state on rising edge.
reset_n  in  1  asynchronous active-low reset.
line_load  in  1  capture line attributes this cycle.
wall  in  2  wall texture ID.
side  in  1  1 = light side, 0 = dark side.
size  in  SIZE_BITS  wall half-height.
texu  in  TEX_BITS  texture u for this line.
vinf  in  1  infinite-height mode.
leak  in  TEX_BITS  floor-leak threshold on texv.
pix_valid  in  1  hpos/texv valid this cycle.
hpos  in  HPOS_BITS  current trace position.
texv  in  TEX_BITS  texture v for this pixel.
ext_en  in  1  select external texel instead of generated (sampled with pix_valid).
ext_rgb  in  6  external texel, BBGGRR; must be valid the cycle after its pix_valid.
bg_rgb  in  6  background colour for non-hit pixels (sampled with pix_valid).
out_valid  out  1  rgb/hit valid.
hit  out  1  pixel lies on wall.
rgb  out  6  final pixel colour, BBGGRR.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, hit=0, rgb=0.
  - All pipeline valids cleared.
  - Line registers: wall=0, side=0, size=0, texu=0, vinf=0, leak=0, full=0, span_lo=span_hi=HALF.
- Reset mid-line drops every in-flight pixel. No output is produced until a new pix_valid arrives after reset release.
- line_load: on the next edge, register wall/side/texu/vinf/leak and compute span:
  - full = (size > HALF).
  - Otherwise span_lo = HALF - size and span_hi = min(HALF + size, H_VIEW - 1).
  - All span comparisons are done at HPOS_BITS+1 width, unsigned.
- A pixel with pix_valid in the same cycle as line_load is discarded: no output is produced for it.
- Stage 1 (edge after pix_valid) registers:
  - v1 = 1.
  - hit1 = (texv >= leak) & (vinf | ((hpos < HALF | texv != 0) & (full | (span_lo <= hpos <= span_hi)))).
  - texu, texv, ext_en, bg_rgb, and line wall/side.
- Stage 2 (next edge):
  - out_valid = v1.
  - hit = hit1.
  - rgb = !hit1 ? bg_rgb1 : ext_en1 ? dim(ext_rgb) : gen.
  - dim: if side=1, pass through. If side=0, each 2-bit channel is shifted right by 1 (11->01, 10->01, 01->00).
- Latency: pixel at cycle N -> outputs valid after edge N+2. Throughput is 1 pixel/clock, with no stalls.
- When v1=0, out_valid=0 and hit=0; rgb holds its last value.
- Generated texture (u = texu1, v = texv1), BBGGRR:
  - wall 0: solid red; light 00_00_11, dark 00_00_10.
  - wall 1: {u0,side,u2,side,u4,side} XOR {v0,0,v2,0,v4,0}.
  - wall 2 (bricks):
    - mortar when (u[4:0]==6 & v3==0) | (u[4:0]==24 & v3==1): light 10_10_10, dark 01_01_01.
    - else v[2:0]==0: u0 ? (light 01_01_01 / dark 00_00_00) : (light 10_10_10 / dark 01_01_01).
    - else v[2:0]==7: light 11_01_00, dark 11_00_00.
    - else v[2:0]==1: light 01_00_00, dark 00_00_00.
    - else light 11_00_00, dark 10_00_00.
  - wall 3 (panels):
    - u[3:1]==0 | v[3:1]==7: light 11_01_11, dark 10_00_10.
    - else u[3:1]==7 | v[3:1]==0: light 10_00_10, dark 01_00_01.
    - else light 10_00_11, dark 01_00_10.
- Boundaries:
  - size=0 gives span_lo=span_hi=HALF (1 pixel).
  - size=HALF is not full; span is 0..H_VIEW-1.
  - size at max SIZE_BITS value has no overflow (full).
  - leak=0 never masks.
  - Overlapping pixels across a line_load: pixels already in stage 1 finish with their captured attributes.

Test Plan:
1. Reset release, load size=100, leak=0, vinf=0; sweep hpos 0..639 with texv=5 -> hit=1 exactly for hpos 220..420. First out_valid appears 2 cycles after first pix_valid.
2. Load size=400 (full): hpos=639, texv=0 -> hit=0; hpos=100, texv=0 -> hit=1; hpos=639, texv=1 -> hit=1.
3. Load leak=10, vinf=1, size=0: hpos=0, texv=9 -> hit=0, rgb=bg_rgb; hpos=0, texv=10 -> hit=1.
4. wall=2, side=1, hit pixel with texu=6, texv=0x03 -> rgb=10_10_10. Then ext_en=1, side=0, ext_rgb=11_10_01 on cycle N+1 -> rgb=01_01_00.
5. line_load and pix_valid in the same cycle -> no out_valid 2 cycles later. The pixel on the following cycle uses the new span.
6. Stream continuous pixels, pulse reset_n low mid-stream -> out_valid/hit/rgb go to 0 asynchronously. After release, hit for hpos=HALF only (size=0).
